// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EX/MEM and MEM/WB.
// Issues single-beat request/ready transactions on the data-memory bus,
// lane-aligns store data and byte enables, formats load data, stalls on
// wait states and holds the MEM/WB pipeline register.
// Optional feature: define MEM_STAGE_MISALIGN_TRAP_EN to trap misaligned
// accesses (adds mem_misalign). Otherwise offsets are forced to natural
// alignment and the access proceeds.
module mem_stage #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [31:0]       ex_mem_pc_p4,
    input  logic [4:0]        ex_mem_rd,
    input  logic [31:0]       ex_mem_alu_result,
    input  logic              ex_mem_mem_read,
    input  logic              ex_mem_mem_write,
    input  logic [3:0]        ex_mem_mem_data_mask,
    input  logic              ex_mem_mem_read_sign_extend,
    input  logic [31:0]       ex_mem_mem_write_data,
    input  logic              ex_mem_reg_write,
    input  logic [1:0]        ex_mem_reg_write_src,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_ready,
    input  logic [31:0]       dmem_rdata,
    output logic              mem_stall,
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    output logic              mem_misalign,
`endif
    output logic [31:0]       mem_wb_pc_p4,
    output logic [4:0]        mem_wb_rd,
    output logic [31:0]       mem_wb_alu_result,
    output logic [31:0]       mem_wb_load_data,
    output logic              mem_wb_reg_write,
    output logic [1:0]        mem_wb_reg_write_src
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t      state_q, state_d;
    logic        acc;
    logic        is_byte, is_half;
    logic [1:0]  off_raw;
    logic [1:0]  off;
    logic        trap;
    logic        req_raw;
    logic [31:0] rdata_sh;
    logic [31:0] load_fmt;
    logic [31:0] load_data_d;

    logic [31:0] pc_p4_q;
    logic [4:0]  rd_q;
    logic [31:0] alu_result_q;
    logic [31:0] load_data_q;
    logic        reg_write_q;
    logic [1:0]  reg_write_src_q;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    logic        misalign_q;
`endif

    assign acc     = ex_mem_mem_read | ex_mem_mem_write;
    assign is_byte = (ex_mem_mem_data_mask == 4'b0001);
    assign is_half = (ex_mem_mem_data_mask == 4'b0011);
    assign off_raw = ex_mem_alu_result[1:0];

    // Effective lane offset and misalignment trap decision
    always_comb begin
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        off  = off_raw;
        trap = acc & (is_half ? off_raw[0] : (~is_byte & (|off_raw)));
`else
        trap = 1'b0;
        if (is_byte) begin
            off = off_raw;
        end else if (is_half) begin
            off = {off_raw[1], 1'b0};
        end else begin
            off = 2'b00;
        end
`endif
    end

    // FSM next-state and raw request generation
    always_comb begin
        state_d = state_q;
        req_raw = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc && !trap) begin
                    req_raw = 1'b1;
                    if (!dmem_ready) begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                req_raw = 1'b1;
                if (dmem_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request gated by reset so an in-flight access drops immediately
    assign dmem_req   = req_raw & rstn;
    assign mem_stall  = dmem_req & ~dmem_ready;
    assign dmem_we    = ex_mem_mem_write;
    assign dmem_addr  = {ex_mem_alu_result[ADDR_W-1:2], 2'b00};
    assign dmem_be    = ex_mem_mem_data_mask << off;
    assign dmem_wdata = ex_mem_mem_write_data << {off, 3'b000};

    // Load data formatting: lane shift, then size/sign extension
    always_comb begin
        rdata_sh = dmem_rdata >> {off, 3'b000};
        case (ex_mem_mem_data_mask)
            4'b0001: load_fmt = {{24{ex_mem_mem_read_sign_extend & rdata_sh[7]}},  rdata_sh[7:0]};
            4'b0011: load_fmt = {{16{ex_mem_mem_read_sign_extend & rdata_sh[15]}}, rdata_sh[15:0]};
            default: load_fmt = rdata_sh;
        endcase
        load_data_d = '0;
        if (ex_mem_mem_read && !ex_mem_mem_write && !trap) begin
            load_data_d = load_fmt;
        end
    end

    // MEM/WB pipeline register: bubble on stall, capture otherwise
    always_ff @(posedge clk) begin
        if (!rstn || mem_stall) begin
            pc_p4_q         <= '0;
            rd_q            <= '0;
            alu_result_q    <= '0;
            load_data_q     <= '0;
            reg_write_q     <= 1'b0;
            reg_write_src_q <= '0;
        end else begin
            pc_p4_q         <= ex_mem_pc_p4;
            rd_q            <= ex_mem_rd;
            alu_result_q    <= ex_mem_alu_result;
            load_data_q     <= load_data_d;
            reg_write_q     <= ex_mem_reg_write & ~trap;
            reg_write_src_q <= ex_mem_reg_write_src;
        end
    end

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    // One-cycle misalignment pulse following a trapped access
    always_ff @(posedge clk) begin
        if (!rstn) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= trap;
        end
    end

    assign mem_misalign = misalign_q;
`endif

    assign mem_wb_pc_p4         = pc_p4_q;
    assign mem_wb_rd            = rd_q;
    assign mem_wb_alu_result    = alu_result_q;
    assign mem_wb_load_data     = load_data_q;
    assign mem_wb_reg_write     = reg_write_q;
    assign mem_wb_reg_write_src = reg_write_src_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized self-checking bench for mem_stage with a
// behavioural reference model of the access rules. Build with or without
// MEM_STAGE_MISALIGN_TRAP_EN to match the RTL configuration.
module tb_mem_stage;

    logic        clk;
    logic        rstn;
    logic [31:0] ex_mem_pc_p4;
    logic [4:0]  ex_mem_rd;
    logic [31:0] ex_mem_alu_result;
    logic        ex_mem_mem_read;
    logic        ex_mem_mem_write;
    logic [3:0]  ex_mem_mem_data_mask;
    logic        ex_mem_mem_read_sign_extend;
    logic [31:0] ex_mem_mem_write_data;
    logic        ex_mem_reg_write;
    logic [1:0]  ex_mem_reg_write_src;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        mem_stall;
    logic        mem_misalign;
    logic [31:0] mem_wb_pc_p4;
    logic [4:0]  mem_wb_rd;
    logic [31:0] mem_wb_alu_result;
    logic [31:0] mem_wb_load_data;
    logic        mem_wb_reg_write;
    logic [1:0]  mem_wb_reg_write_src;

    int unsigned total;
    int unsigned bad;

    mem_stage #(.ADDR_W(32)) dut (
        .clk                        (clk),
        .rstn                       (rstn),
        .ex_mem_pc_p4               (ex_mem_pc_p4),
        .ex_mem_rd                  (ex_mem_rd),
        .ex_mem_alu_result          (ex_mem_alu_result),
        .ex_mem_mem_read            (ex_mem_mem_read),
        .ex_mem_mem_write           (ex_mem_mem_write),
        .ex_mem_mem_data_mask       (ex_mem_mem_data_mask),
        .ex_mem_mem_read_sign_extend(ex_mem_mem_read_sign_extend),
        .ex_mem_mem_write_data      (ex_mem_mem_write_data),
        .ex_mem_reg_write           (ex_mem_reg_write),
        .ex_mem_reg_write_src       (ex_mem_reg_write_src),
        .dmem_req                   (dmem_req),
        .dmem_we                    (dmem_we),
        .dmem_addr                  (dmem_addr),
        .dmem_wdata                 (dmem_wdata),
        .dmem_be                    (dmem_be),
        .dmem_ready                 (dmem_ready),
        .dmem_rdata                 (dmem_rdata),
        .mem_stall                  (mem_stall),
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        .mem_misalign               (mem_misalign),
`endif
        .mem_wb_pc_p4               (mem_wb_pc_p4),
        .mem_wb_rd                  (mem_wb_rd),
        .mem_wb_alu_result          (mem_wb_alu_result),
        .mem_wb_load_data           (mem_wb_load_data),
        .mem_wb_reg_write           (mem_wb_reg_write),
        .mem_wb_reg_write_src       (mem_wb_reg_write_src)
    );

`ifndef MEM_STAGE_MISALIGN_TRAP_EN
    assign mem_misalign = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // One access through the stage; waits = ready-low cycles before ready.
    task automatic run_txn(input bit rd, input bit wr, input logic [3:0] mask,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input bit sx,
                           input int unsigned waits_in, input bit regw,
                           input logic [4:0] rd_idx);
        int unsigned size, off_raw, off, waits;
        bit acc, mis, trap, exp_req;
        logic [31:0] exp_load, szmask, v;
        logic [3:0]  exp_be;
        logic [31:0] pc;
        logic [1:0]  src;

        pc   = $urandom;
        src  = 2'($urandom_range(0, 3));
        acc  = rd || wr;
        size = (mask == 4'b0001) ? 1 : (mask == 4'b0011) ? 2 : 4;
        off_raw = addr % 4;
        mis  = (size == 2 && (off_raw % 2) != 0) || (size == 4 && off_raw != 0);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        trap = acc && mis;
        off  = off_raw;
`else
        trap = 1'b0;
        off  = off_raw - (off_raw % size);
`endif
        exp_req = acc && !trap;
        waits   = exp_req ? waits_in : 0;
        exp_be  = 4'((32'(mask) << off) & 32'hF);

        exp_load = 32'h0;
        if (rd && !wr && exp_req) begin
            v = rdata >> (8 * off);
            if (size < 4) begin
                szmask = (32'h1 << (8 * size)) - 32'h1;
                v = v & szmask;
                if (sx && ((v >> (8 * size - 1)) & 32'h1) == 32'h1)
                    v = v | ~szmask;
            end
            exp_load = v;
        end

        for (int unsigned c = 0; c <= waits; c++) begin
            @(negedge clk);
            ex_mem_pc_p4                = pc;
            ex_mem_rd                   = rd_idx;
            ex_mem_alu_result           = addr;
            ex_mem_mem_read             = rd;
            ex_mem_mem_write            = wr;
            ex_mem_mem_data_mask        = mask;
            ex_mem_mem_read_sign_extend = sx;
            ex_mem_mem_write_data       = wdata;
            ex_mem_reg_write            = regw;
            ex_mem_reg_write_src        = src;
            dmem_ready                  = (c == waits);
            dmem_rdata                  = (c == waits) ? rdata : $urandom;
            #1;
            check("req", 32'(dmem_req), 32'(exp_req));
            check("stall", 32'(mem_stall), 32'(exp_req && c < waits));
            if (exp_req) begin
                check("we", 32'(dmem_we), 32'(wr));
                check("addr", dmem_addr, addr & ~32'h3);
                check("be", 32'(dmem_be), 32'(exp_be));
                check("wdata", dmem_wdata, wdata << (8 * off));
            end
            @(posedge clk);
            #1;
            if (c < waits) begin
                check("bub_regw", 32'(mem_wb_reg_write), 32'h0);
                check("bub_rd", 32'(mem_wb_rd), 32'h0);
                check("bub_pc", mem_wb_pc_p4, 32'h0);
            end else begin
                check("wb_pc", mem_wb_pc_p4, pc);
                check("wb_rd", 32'(mem_wb_rd), 32'(rd_idx));
                check("wb_alu", mem_wb_alu_result, addr);
                check("wb_regw", 32'(mem_wb_reg_write), 32'(regw && !trap));
                check("wb_src", 32'(mem_wb_reg_write_src), 32'(src));
                check("wb_load", mem_wb_load_data, exp_load);
                check("misalign", 32'(mem_misalign), 32'(trap));
            end
        end
    endtask

    initial begin
        logic [3:0] m;
        int unsigned sel;
        total = 0;
        bad   = 0;
        rstn = 1'b0;
        ex_mem_pc_p4 = '0; ex_mem_rd = '0; ex_mem_alu_result = '0;
        ex_mem_mem_read = 1'b0; ex_mem_mem_write = 1'b0;
        ex_mem_mem_data_mask = 4'b1111; ex_mem_mem_read_sign_extend = 1'b0;
        ex_mem_mem_write_data = '0; ex_mem_reg_write = 1'b0;
        ex_mem_reg_write_src = '0; dmem_ready = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_regw", 32'(mem_wb_reg_write), 32'h0);
        check("rst_pc", mem_wb_pc_p4, 32'h0);
        check("rst_load", mem_wb_load_data, 32'h0);
        check("rst_misalign", 32'(mem_misalign), 32'h0);
        check("rst_req", 32'(dmem_req), 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        // Directed cases
        run_txn(0, 1, 4'b1111, 32'h104, 32'hDEADBEEF, 32'h0, 0, 0, 0, 5'd0);
        run_txn(0, 1, 4'b0001, 32'h103, 32'h000000AB, 32'h0, 0, 0, 0, 5'd0);
        run_txn(1, 0, 4'b0001, 32'h102, 32'h0, 32'h12F45678, 1, 0, 1, 5'd5);
        run_txn(1, 0, 4'b0001, 32'h102, 32'h0, 32'h12F45678, 0, 0, 1, 5'd5);
        run_txn(1, 0, 4'b0011, 32'h202, 32'h0, 32'h80010000, 0, 3, 1, 5'd9);
        run_txn(1, 0, 4'b1111, 32'h101, 32'h0, 32'hCAFEBABE, 0, 0, 1, 5'd3);
        run_txn(1, 1, 4'b1111, 32'h200, 32'h11223344, 32'h55667788, 1, 0, 1, 5'd4);
        run_txn(0, 0, 4'b1111, 32'h300, 32'h0, 32'h0, 0, 0, 1, 5'd12);

        // Randomized accesses
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            m = (sel < 3) ? 4'b0001 : (sel < 6) ? 4'b0011 : (sel < 9) ? 4'b1111 : 4'($urandom);
            sel = $urandom_range(0, 5);
            run_txn(sel == 0 || sel >= 3, sel == 1 || sel == 5, m, $urandom, $urandom,
                    $urandom, 1'($urandom), $urandom_range(0, 3), 1'($urandom),
                    5'($urandom));
        end

        // Reset asserted while an access is in WAIT
        @(negedge clk);
        ex_mem_mem_read = 1'b1; ex_mem_mem_write = 1'b0;
        ex_mem_mem_data_mask = 4'b1111; ex_mem_alu_result = 32'h300;
        ex_mem_reg_write = 1'b1; ex_mem_rd = 5'd7; ex_mem_pc_p4 = 32'h44;
        dmem_ready = 1'b0;
        #1;
        check("rw_stall", 32'(mem_stall), 32'h1);
        @(posedge clk);
        #1;
        check("rw_bubble", 32'(mem_wb_reg_write), 32'h0);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("rw_req_drop", 32'(dmem_req), 32'h0);
        check("rw_stall_drop", 32'(mem_stall), 32'h0);
        @(posedge clk);
        #1;
        check("rw_regw", 32'(mem_wb_reg_write), 32'h0);
        check("rw_rd", 32'(mem_wb_rd), 32'h0);
        check("rw_pc", mem_wb_pc_p4, 32'h0);
        check("rw_alu", mem_wb_alu_result, 32'h0);
        check("rw_load", mem_wb_load_data, 32'h0);
        check("rw_src", 32'(mem_wb_reg_write_src), 32'h0);
        @(negedge clk);
        ex_mem_mem_read = 1'b0; ex_mem_reg_write = 1'b0; ex_mem_rd = '0;
        rstn = 1'b1;
        dmem_ready = 1'b1;
        dmem_rdata = 32'hA5A5A5A5;
        #1;
        check("late_req", 32'(dmem_req), 32'h0);
        @(posedge clk);
        #1;
        check("late_regw", 32'(mem_wb_reg_write), 32'h0);
        check("late_load", mem_wb_load_data, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
